rs_issue_select: RTL and testbench
==================================

# rs_issue_select

Issue-select stage between the reservation-station array and one functional unit. Each cycle it round-robin arbitrates among RS entries reporting ready, asserts the winning entry's use-enable/free strobe, and captures that entry's operands and tags into an issue register. The register presents them to the functional unit under a valid/ready handshake. A flush input squashes the issue register on mispredict recovery.

## Interface
Parameters:
- NUM_RS, 8, number of RS entries arbitrated (power of two, 2..16)
- PRN_BITS, 6, physical register tag width
- ROB_BITS, 5, ROB index width

Ports:
- clock  in  1  single clock; all state updates on posedge
- reset  in  1  synchronous, active-high reset
- flush  in  1  squash issue register and suppress grant this cycle
- rs_ready_in  in  NUM_RS  per-entry ready (InUse & both operands valid)
- rs_opa_in  in  64  wired-OR operand A bus; only the enabled entry drives non-zero
- rs_opb_in  in  64  wired-OR operand B bus
- rs_func_in  in  5*NUM_RS  packed FunctionCode per entry; entry i at [5i+4:5i]
- rs_prn_in  in  PRN_BITS*NUM_RS  packed destination PR per entry
- rs_rob_in  in  ROB_BITS*NUM_RS  packed ROB index per entry
- rs_use_enable_out  out  NUM_RS  one-hot, combinational; gates winner onto operand buses
- rs_free_out  out  NUM_RS  one-hot, identical to rs_use_enable_out; frees winner at next edge
- ex_valid_out  out  1  issue register holds an instruction
- ex_ready_in  in  1  FU accepts the instruction this cycle
- ex_opa_out, ex_opb_out  out  64 each  issued operands
- ex_func_out  out  5  issued FunctionCode
- ex_prn_out  out  PRN_BITS  issued destination PR
- ex_rob_out  out  ROB_BITS  issued ROB index
- stall_count_out  out  16  saturating count of cycles with ready work but blocked issue slot

## Operation
- slot_open = ~ex_valid_out | ex_ready_in.
- grant_en = slot_open & ~flush & ~reset & (|rs_ready_in).
- Arbitration: round-robin starting at ptr (ptr..NUM_RS-1, then 0..ptr-1); the first ready index g wins. At most one bit of rs_use_enable_out is set, and only when grant_en is high.
- On grant: capture rs_opa_in, rs_opb_in, func/prn/rob slice g into the issue register; ex_valid_out <= 1; ptr <= (g+1) mod NUM_RS.
- No grant and ex_ready_in & ex_valid_out: ex_valid_out <= 0; data registers hold their values.
- No grant, slot not open: hold all state (back-pressure).
- flush: ex_valid_out <= 0; no use_enable/free asserted; ptr holds. Flush overrides ex_ready_in and pending grants.
- stall_count: increments when (|rs_ready_in) & ~slot_open & ~flush, and saturates at 16'hFFFF.
- Dispatch never loads an entry that is InUse, so a freed entry never coincides with a load into the same entry.

## Timing
- Reset (synchronous, at posedge while reset=1): ex_valid_out=0, ex_opa_out=0, ex_opb_out=0, ex_func_out=0, ex_prn_out=0, ex_rob_out=0, ptr=0, stall_count_out=0. rs_use_enable_out/rs_free_out are 0 while reset is high.
- Latency: entry ready in cycle N → use_enable/free asserted in cycle N (combinational) → ex_valid_out and data visible in cycle N+1. The RS entry's InUse clears at the same N+1 edge.
- Throughput: one issue per cycle when the FU holds ex_ready_in high. A simultaneous drain and grant refills the register with no bubble.
- Outputs are stable while ex_valid_out=1 and ex_ready_in=0.
- ptr wraps from NUM_RS-1 to 0.
- Reset mid-handshake discards the held instruction; no free pulse is emitted.

## Test plan
- Reset: assert reset 2 cycles with rs_ready_in=8'hFF → all outputs 0, no use_enable; release → cycle 1 grants entry 0 and ex_valid_out rises next cycle.
- Round-robin: rs_ready_in=8'hFF held, ex_ready_in=1 → grants 0,1,…,7,0 on consecutive cycles; each ex_rob_out equals the packed ROB of that entry.
- Sparse/wrap: ptr=6, rs_ready_in=8'b0010_0001 → grant entry 0, ptr becomes 1; next grant is entry 5.
- Back-pressure: ex_valid_out=1, ex_ready_in=0, rs_ready_in=8'h04 for 5 cycles → no use_enable, outputs frozen, stall_count_out=5; raise ex_ready_in → entry 2 granted that cycle.
- Flush: ex_valid_out=1 with ROB 3, flush=1, rs_ready_in=8'h01 → next cycle ex_valid_out=0, rs_free_out=0 during flush, ptr unchanged; the following cycle entry 0 is granted.
- Counter saturation: force 70000 blocked cycles → stall_count_out stops at 16'hFFFF.

Source files
------------

// File: rtl/rs_issue_select.sv
// rs_issue_select: round-robin pick of a ready RS entry, captured into a valid/ready issue register.
module rs_issue_select #(
  parameter int NUM_RS   = 8,
  parameter int PRN_BITS = 6,
  parameter int ROB_BITS = 5
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         flush,
  input  logic [NUM_RS-1:0]            rs_ready_in,
  input  logic [63:0]                  rs_opa_in,
  input  logic [63:0]                  rs_opb_in,
  input  logic [5*NUM_RS-1:0]          rs_func_in,
  input  logic [PRN_BITS*NUM_RS-1:0]   rs_prn_in,
  input  logic [ROB_BITS*NUM_RS-1:0]   rs_rob_in,
  output logic [NUM_RS-1:0]            rs_use_enable_out,
  output logic [NUM_RS-1:0]            rs_free_out,
  output logic                         ex_valid_out,
  input  logic                         ex_ready_in,
  output logic [63:0]                  ex_opa_out,
  output logic [63:0]                  ex_opb_out,
  output logic [4:0]                   ex_func_out,
  output logic [PRN_BITS-1:0]          ex_prn_out,
  output logic [ROB_BITS-1:0]          ex_rob_out,
  output logic [15:0]                  stall_count_out
);
  localparam int PW = $clog2(NUM_RS);
  logic [PW-1:0] ptr, grant_idx, idx;
  logic found, slot_open, grant_en, any_ready;
  assign any_ready = |rs_ready_in;
  assign slot_open = ~ex_valid_out | ex_ready_in;
  assign grant_en  = slot_open & ~flush & ~reset & any_ready;
  // Scan from ptr upward; NUM_RS is a power of two so the index add wraps naturally.
  always_comb begin
    grant_idx = '0;
    found = 1'b0;
    idx = '0;
    for (int i = 0; i < NUM_RS; i++) begin
      idx = ptr + PW'(i);
      if (!found && rs_ready_in[idx]) begin
        found = 1'b1;
        grant_idx = idx;
      end
    end
  end
  assign rs_use_enable_out = grant_en ? (NUM_RS'(1) << grant_idx) : '0;
  assign rs_free_out = rs_use_enable_out;
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr <= '0;
      ex_valid_out <= 1'b0;
      ex_opa_out <= '0;
      ex_opb_out <= '0;
      ex_func_out <= '0;
      ex_prn_out <= '0;
      ex_rob_out <= '0;
      stall_count_out <= '0;
    end else begin
      if (flush) ex_valid_out <= 1'b0;
      else if (grant_en) begin
        ex_valid_out <= 1'b1;
        ex_opa_out <= rs_opa_in;
        ex_opb_out <= rs_opb_in;
        ex_func_out <= rs_func_in[5*grant_idx +: 5];
        ex_prn_out <= rs_prn_in[PRN_BITS*grant_idx +: PRN_BITS];
        ex_rob_out <= rs_rob_in[ROB_BITS*grant_idx +: ROB_BITS];
        ptr <= grant_idx + PW'(1);
      end else if (ex_ready_in) ex_valid_out <= 1'b0;
      if (any_ready && !slot_open && !flush && stall_count_out != 16'hFFFF)
        stall_count_out <= stall_count_out + 16'd1;
    end
  end
endmodule

// File: tb/tb_rs_issue_select.sv
// tb_rs_issue_select: random and directed stimulus checked against a behavioural issue-slot model.
module tb_rs_issue_select;
  localparam int N = 8, PB = 6, RB = 5;
  logic clock = 0, reset = 1, flush = 0, ex_ready_in = 0;
  logic [N-1:0] rs_ready_in = '0;
  logic [63:0] opa_bus, opb_bus;
  logic [5*N-1:0] func_bus;
  logic [PB*N-1:0] prn_bus;
  logic [RB*N-1:0] rob_bus;
  logic [N-1:0] use_en, free;
  logic ex_valid_out;
  logic [63:0] ex_opa_out, ex_opb_out;
  logic [4:0] ex_func_out;
  logic [PB-1:0] ex_prn_out;
  logic [RB-1:0] ex_rob_out;
  logic [15:0] stall_count_out;
  logic [63:0] opa_a [N], opb_a [N];
  logic [4:0] func_a [N];
  logic [PB-1:0] prn_a [N];
  logic [RB-1:0] rob_a [N];
  int errors = 0, checks = 0;
  int m_ptr, m_stall;
  bit m_valid;
  logic [63:0] m_opa, m_opb;
  logic [4:0] m_func;
  logic [PB-1:0] m_prn;
  logic [RB-1:0] m_rob;

  rs_issue_select #(.NUM_RS(N), .PRN_BITS(PB), .ROB_BITS(RB)) dut (
    .clock(clock), .reset(reset), .flush(flush), .rs_ready_in(rs_ready_in),
    .rs_opa_in(opa_bus), .rs_opb_in(opb_bus), .rs_func_in(func_bus),
    .rs_prn_in(prn_bus), .rs_rob_in(rob_bus), .rs_use_enable_out(use_en),
    .rs_free_out(free), .ex_valid_out(ex_valid_out), .ex_ready_in(ex_ready_in),
    .ex_opa_out(ex_opa_out), .ex_opb_out(ex_opb_out), .ex_func_out(ex_func_out),
    .ex_prn_out(ex_prn_out), .ex_rob_out(ex_rob_out), .stall_count_out(stall_count_out));

  always #5 clock = ~clock;

  // Behaves like the RS array: only the enabled entry drives the wired-OR operand buses.
  always_comb begin
    opa_bus = '0;
    opb_bus = '0;
    for (int i = 0; i < N; i++) begin
      if (use_en[i]) begin
        opa_bus = opa_bus | opa_a[i];
        opb_bus = opb_bus | opb_a[i];
      end
      func_bus[5*i +: 5] = func_a[i];
      prn_bus[PB*i +: PB] = prn_a[i];
      rob_bus[RB*i +: RB] = rob_a[i];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic new_data();
    for (int i = 0; i < N; i++) begin
      opa_a[i] = {$urandom, $urandom};
      opb_a[i] = {$urandom, $urandom};
      func_a[i] = 5'($urandom);
      prn_a[i] = PB'($urandom);
      rob_a[i] = RB'($urandom);
    end
  endtask

  function automatic int pick();
    for (int k = 0; k < N; k++)
      if (rs_ready_in[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  // One clock: inputs already driven; check grant, advance model at the edge, check register.
  task automatic step(input bit chk);
    int g;
    bit open, gen;
    logic [N-1:0] exp_en;
    #2;
    open = !m_valid || ex_ready_in;
    g = pick();
    gen = open && !flush && !reset && g >= 0;
    exp_en = gen ? N'(1) << g : '0;
    if (chk) begin
      check("use_enable", 64'(use_en), 64'(exp_en));
      check("free", 64'(free), 64'(exp_en));
    end
    @(posedge clock);
    if (reset) begin
      m_ptr = 0; m_valid = 0; m_stall = 0;
      m_opa = 0; m_opb = 0; m_func = 0; m_prn = 0; m_rob = 0;
    end else begin
      if (g >= 0 && !open && !flush && m_stall < 65535) m_stall++;
      if (flush) m_valid = 0;
      else if (gen) begin
        m_valid = 1;
        m_opa = opa_a[g]; m_opb = opb_a[g]; m_func = func_a[g];
        m_prn = prn_a[g]; m_rob = rob_a[g];
        m_ptr = (g + 1) % N;
      end else if (ex_ready_in) m_valid = 0;
    end
    #1;
    if (chk) begin
      check("ex_valid", 64'(ex_valid_out), 64'(m_valid));
      check("ex_opa", ex_opa_out, m_opa);
      check("ex_opb", ex_opb_out, m_opb);
      check("ex_func", 64'(ex_func_out), 64'(m_func));
      check("ex_prn", 64'(ex_prn_out), 64'(m_prn));
      check("ex_rob", 64'(ex_rob_out), 64'(m_rob));
      check("stall_count", 64'(stall_count_out), 64'(m_stall));
    end
  endtask

  task automatic drive(input bit rst, input logic [N-1:0] rdy, input bit exr, input bit fl);
    reset = rst; rs_ready_in = rdy; ex_ready_in = exr; flush = fl;
    new_data();
    step(1);
  endtask

  initial begin
    new_data();
    drive(1, 8'hFF, 0, 0);
    drive(1, 8'hFF, 0, 0);
    check("reset_valid", 64'(ex_valid_out), 0);
    drive(0, 8'hFF, 1, 0);
    check("first_grant_rob", 64'(ex_rob_out), 64'(rob_a[0]));
    for (int i = 0; i < 9; i++) drive(0, 8'hFF, 1, 0);
    // ptr is now 2; walk it to 6 then exercise the sparse wrap.
    for (int i = 0; i < 4; i++) drive(0, 8'hFF, 1, 0);
    drive(0, 8'b0010_0001, 1, 0);
    check("wrap_grant_rob", 64'(ex_rob_out), 64'(rob_a[0]));
    drive(0, 8'b0010_0001, 1, 0);
    check("sparse_grant_rob", 64'(ex_rob_out), 64'(rob_a[5]));
    drive(1, 8'h00, 0, 0);
    drive(0, 8'h04, 0, 0);
    for (int i = 0; i < 5; i++) drive(0, 8'h04, 0, 0);
    check("stall_after_5", 64'(stall_count_out), 5);
    drive(0, 8'h04, 1, 0);
    drive(0, 8'h01, 0, 1);
    check("flush_valid", 64'(ex_valid_out), 0);
    drive(0, 8'h01, 0, 0);
    check("post_flush_rob", 64'(ex_rob_out), 64'(rob_a[0]));
    for (int i = 0; i < 600; i++)
      drive($urandom_range(0, 63) == 0, N'($urandom), $urandom_range(0, 3) != 0,
            $urandom_range(0, 15) == 0);
    drive(1, 8'h00, 0, 0);
    drive(0, 8'h01, 0, 0);
    reset = 0; rs_ready_in = 8'h01; ex_ready_in = 0; flush = 0;
    for (int i = 0; i < 70000; i++) step(0);
    step(1);
    check("stall_saturated", 64'(stall_count_out), 64'hFFFF);
    drive(0, 8'h01, 1, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
